// File: rtl/memwb_stage.sv
// memwb_stage: MEM/WB pipeline register with a load-capture queue.
// Data-cache responses (dhit/dload) are queued in a small circular FIFO.
// Load instructions drain that FIFO as they advance into writeback.
// Optional build macro: MEMWB_LOAD_BYPASS_EN. When it is defined, a load that
// finds the queue empty takes a same-cycle dload directly.
module memwb_stage #(
   parameter int PAY_W    = 96,
   parameter int CTRL_W   = 16,
   parameter int LOAD_W   = 32,
   parameter int LQ_DEPTH = 2,
   localparam int CNT_W   = $clog2(LQ_DEPTH + 1),
   localparam int PTR_W   = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ihit,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              in_isload,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [PAY_W-1:0]  in_pay,
   input  logic              dhit,
   input  logic [LOAD_W-1:0] dload,
   output logic              out_valid,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [PAY_W-1:0]  out_pay,
   output logic [LOAD_W-1:0] out_load,
   output logic [CNT_W-1:0]  lq_count,
   output logic              lq_full,
   output logic              lq_overflow,
   output logic              lq_underflow
);

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [PAY_W-1:0]  pay_q, pay_d;
   logic [LOAD_W-1:0] load_q, load_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [LOAD_W-1:0] mem_q [LQ_DEPTH];

   logic              adv;
   logic              lq_empty;
   logic              lq_full_w;
   logic              pop_req;
   logic              pop;
   logic              bypass;
   logic              push_req;
   logic              push;
   logic              ovf_set;
   logic              unf_set;
   logic [LOAD_W-1:0] head;

   // Pointer increment that wraps at LQ_DEPTH, so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(LQ_DEPTH - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   assign adv       = ihit & ~stall;
   assign lq_empty  = (count_q == '0);
   assign lq_full_w = (count_q == CNT_W'(LQ_DEPTH));
   assign pop_req   = adv & in_valid & in_isload;
   assign pop       = pop_req & ~lq_empty & ~flush;
   assign head      = mem_q[rptr_q];

`ifdef MEMWB_LOAD_BYPASS_EN
   assign bypass    = pop_req & lq_empty & dhit & ~flush;
`else
   assign bypass    = 1'b0;
`endif

   // A full queue still accepts a push when the head leaves in the same cycle.
   assign push_req  = dhit & ~flush & ~bypass;
   assign push      = push_req & (~lq_full_w | pop);
   assign ovf_set   = push_req & lq_full_w & ~pop;
   assign unf_set   = pop_req & lq_empty & ~bypass & ~flush;

   // Next-state logic: flush wins, then advance; the queue runs independently of advance.
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      pay_d   = pay_q;
      load_d  = load_q;
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      ovf_d   = ovf_q | ovf_set;
      unf_d   = unf_q | unf_set;
      if (flush) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         pay_d   = '0;
         load_d  = '0;
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         if (adv) begin
            valid_d = in_valid;
            ctrl_d  = in_ctrl;
            pay_d   = in_pay;
            if (pop) begin
               load_d = head;
            end else if (bypass) begin
               load_d = dload;
            end else if (!in_isload || unf_set) begin
               load_d = '0;
            end
         end
         if (pop) begin
            rptr_d = ptr_inc(rptr_q);
         end
         if (push) begin
            wptr_d = ptr_inc(wptr_q);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         pay_q   <= '0;
         load_q  <= '0;
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         pay_q   <= pay_d;
         load_q  <= load_d;
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Queue storage; contents are don't-care while the count says empty.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wptr_q] <= dload;
      end
   end

   assign out_valid    = valid_q;
   assign out_ctrl     = ctrl_q;
   assign out_pay      = pay_q;
   assign out_load     = load_q;
   assign lq_count     = count_q;
   assign lq_full      = lq_full_w;
   assign lq_overflow  = ovf_q;
   assign lq_underflow = unf_q;

endmodule

// File: doc/memwb_stage.md
MEMWB_STAGE -- requirements
Module: memwb_stage

Interface
REQ-001 SHALL have parameter PAY_W, 96, width of the data payload (ALU result, next PC, store operand).
REQ-002 SHALL have parameter CTRL_W, 16, width of the control bundle (opcode/func, mem-to-reg select, register write enable, destination register, halt).
REQ-003 SHALL have parameter LOAD_W, 32, width of the load data word.
REQ-004 SHALL have parameter LQ_DEPTH, 2, load-capture queue entries; legal range is 1-8.
REQ-005 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port nRST, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port ihit, input, 1, pipeline advance enable.
REQ-008 SHALL have port stall, input, 1, hazard hold; blocks advance.
REQ-009 SHALL have port flush, input, 1, bubble insertion and queue clear.
REQ-010 SHALL have port in_valid, input, 1, upstream instruction valid.
REQ-011 SHALL have port in_isload, input, 1, upstream instruction consumes load data.
REQ-012 SHALL have port in_ctrl, input, CTRL_W, upstream control bundle.
REQ-013 SHALL have port in_pay, input, PAY_W, upstream payload.
REQ-014 SHALL have port dhit, input, 1, data-cache response strobe.
REQ-015 SHALL have port dload, input, LOAD_W, data-cache response word.
REQ-016 SHALL have outputs out_valid (1), out_ctrl (CTRL_W), out_pay (PAY_W) and out_load (LOAD_W), the registered writeback-side values.
REQ-017 SHALL have outputs lq_count (clog2(LQ_DEPTH+1)), lq_full (1), lq_overflow (1, sticky) and lq_underflow (1, sticky).

Function
REQ-018 adv = ihit AND NOT stall; out_valid, out_ctrl and out_pay SHALL load their in_* values on the cycle after adv, one cycle of latency, and hold otherwise.
REQ-019 dhit SHALL push dload into a circular FIFO of LQ_DEPTH entries, with read and write pointers wrapping modulo LQ_DEPTH.
REQ-020 A pop SHALL occur when adv, in_valid and in_isload are all 1 and the queue is non-empty; out_load SHALL take the head entry.
REQ-021 On adv without a pop, out_load SHALL be zero when in_isload is 0, and SHALL hold its value otherwise.
REQ-022 A push and a pop in the same cycle SHALL leave lq_count unchanged and SHALL be legal when the queue is full.
REQ-023 A push when full with no same-cycle pop SHALL drop dload and set lq_overflow.
REQ-024 A pop request with an empty queue and no bypass (REQ-029) SHALL set lq_underflow, and out_load SHALL become 0.
REQ-025 lq_full SHALL equal (lq_count == LQ_DEPTH); lq_count SHALL be registered.
REQ-026 flush SHALL take priority over adv and stall: next cycle out_valid=0, out_ctrl=0, out_pay=0, out_load=0, queue empty; a dhit in the same cycle SHALL be discarded.
REQ-027 The sticky flags SHALL clear only on reset, not on flush.

Reset
REQ-028 While nRST=0, all outputs and pointers SHALL be 0 immediately and independent of CLK; operation SHALL resume on the first rising edge after release, and reset mid-operation SHALL discard queued data.

Configuration
REQ-029 Macro MEMWB_LOAD_BYPASS_EN defined: when a pop is requested with an empty queue and dhit=1 in the same cycle, dload SHALL go directly to out_load, with no enqueue and no underflow.
REQ-030 Macro not defined: that dhit SHALL enqueue, and the empty pop SHALL follow REQ-024.

Verification
REQ-031 Reset, then dhit dload=0xDEADBEEF; next cycle ihit=1, in_isload=1, in_valid=1 -> out_load=0xDEADBEEF, lq_count 1->0.
REQ-032 LQ_DEPTH=2, three dhits (0x1, 0x2, 0x3) with no pop -> lq_full=1, lq_overflow=1; two pops then give 0x1 and 0x2.
REQ-033 Queue full plus simultaneous dhit 0x5 and pop -> head popped, 0x5 enqueued, lq_count stays 2, no overflow.
REQ-034 stall=1, ihit=1, in_pay=0xABC -> out_pay unchanged; with stall=0 next cycle -> out_pay=0xABC.
REQ-035 Queue holding 1 entry, flush=1 with dhit=1 -> out_valid=0, all outputs 0, lq_count=0.
REQ-036 Empty queue, pop with dhit dload=0x77 -> bypass build gives out_load=0x77 and lq_underflow=0; non-bypass build gives out_load=0, lq_underflow=1 and lq_count=1.
